// File: rtl/sn74ls163.sv
// sn74ls163: synchronous 4-bit binary counter with synchronous clear,
// synchronous parallel load and cascadable ripple carry out.
// This is a zero-delay model: TPD_Q and TPD_RCO record the datasheet
// timing of the part but are not applied to the outputs.
module sn74ls163 #(
    parameter int TPD_Q   = 18,
    parameter int TPD_RCO = 20
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load_n,
    input  logic       enp,
    input  logic       ent,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       rco
);

    // Negative delays are meaningless. This empty guard block is the only
    // place the timing parameters are referenced.
    if (TPD_Q < 0 || TPD_RCO < 0) begin : g_neg_tpd
    end

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic       cnt_en;

    // Next-state: clear beats load beats count. A control input that is
    // neither 0 nor 1 poisons the state with x. Synthesis treats the
    // x-branches as unreachable don't-cares.
    always_comb begin
        q_d    = q_q;
        cnt_en = enp & ent;
        if (clr_n == 1'b0) begin
            q_d = 4'b0000;
        end else if (clr_n != 1'b1) begin
            q_d = 4'bxxxx;
        end else if (load_n == 1'b0) begin
            // An x on any bit of d carries through to the same bit of q.
            q_d = d;
        end else if (load_n != 1'b1) begin
            q_d = 4'bxxxx;
        end else if (cnt_en == 1'b1) begin
            // The 4-bit add wraps 1111 -> 0000. No overflow state is kept.
            q_d = q_q + 4'd1;
        end else if (cnt_en != 1'b0) begin
            q_d = 4'bxxxx;
        end
    end

    // State register. Every change to q, including clear, happens on the
    // rising clock edge, so pulses on clr_n or load_n between edges do nothing.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

    // Ripple carry is purely combinational and depends only on ent and q.
    assign rco = ent & (q_q == 4'b1111);

endmodule
